// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with per-stage valid/ready flow control.
// Optional CLA_PIPE_OVF_EN adds a registered signed-overflow output `ovf`.
module cla_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG  = WIDTH / GROUP;
  localparam int GPS = NG / STAGES;

  // One lookahead unit: returns {group carry-out, group sum bits}.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] ga,
                                               input logic [GROUP-1:0] gb,
                                               input logic             gc);
    logic [GROUP-1:0] g, p;
    logic [GROUP-1:0] c;
    logic             pp;
    logic             acc;
    logic             grp_g;
    logic             grp_p;
    g     = ga & gb;
    p     = ga | gb;
    c     = '0;
    c[0]  = gc;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int i = 1; i <= GROUP; i++) begin
      pp  = 1'b1;
      acc = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      if (i == GROUP) begin
        grp_g = acc;
        grp_p = pp;
      end else begin
        c[i] = acc | (pp & gc);
      end
    end
    return {grp_g | (grp_p & gc), (ga ^ gb) ^ c};
  endfunction

  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
  logic [STAGES:0]              rdy;

  logic [WIDTH-1:0] st_a, st_b, st_s, s_new;
  logic             st_c, st_v, c_new;
  logic [GROUP:0]   gr;
  int               kp;

`ifdef CLA_PIPE_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Handshake: a stage takes a new beat when it is empty or its successor
  // takes its current one (ready_k = !valid_k | ready_{k+1}); a beat moves on
  // valid & ready, and a stage that is not ready keeps its contents untouched.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] | rdy[k+1];
    end

    v_d   = v_q;
    c_d   = c_q;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
`ifdef CLA_PIPE_OVF_EN
    ovf_d = ovf_q;
`endif
    st_a  = '0;
    st_b  = '0;
    st_s  = '0;
    st_c  = 1'b0;
    st_v  = 1'b0;
    s_new = '0;
    c_new = 1'b0;
    gr    = '0;
    kp    = 0;

    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        st_a = a;
        st_b = sub ? ~b : b;
        st_c = sub ? 1'b1 : cin;
        st_s = '0;
        st_v = in_valid;
      end else begin
        kp   = k - 1;
        st_a = a_q[kp];
        st_b = b_q[kp];
        st_c = c_q[kp];
        st_s = s_q[kp];
        st_v = v_q[kp];
      end

      // Groups owned by this stage ripple their carries group to group.
      s_new = st_s;
      c_new = st_c;
      for (int gi = 0; gi < GPS; gi++) begin
        gr = cla_group(st_a[(k*GPS+gi)*GROUP +: GROUP],
                       st_b[(k*GPS+gi)*GROUP +: GROUP], c_new);
        s_new[(k*GPS+gi)*GROUP +: GROUP] = gr[GROUP-1:0];
        c_new = gr[GROUP];
      end

      if (rdy[k]) begin
        v_d[k] = st_v;
        if (st_v) begin
          a_d[k] = st_a;
          b_d[k] = st_b;
          s_d[k] = s_new;
          c_d[k] = c_new;
`ifdef CLA_PIPE_OVF_EN
          // Carry into the MSB is recovered as a^b_eff^sum at that bit.
          if (k == STAGES - 1) begin
            ovf_d = st_a[WIDTH-1] ^ st_b[WIDTH-1] ^ s_new[WIDTH-1] ^ c_new;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
`ifdef CLA_PIPE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
`ifdef CLA_PIPE_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
`ifdef CLA_PIPE_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe.sv
// Self-checking bench for cla_pipe: default 32/8/2 instance plus a 16/4/4 instance,
// random stimulus checked against an arithmetic reference model.
module tb_cla_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [15:0] s_a, s_b, s_sum;
  logic        s_cin, s_sub, s_cout;

`ifdef CLA_PIPE_OVF_EN
  logic ovf, s_ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  logic [16:0] exp16_q[$];

  cla_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CLA_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  cla_pipe #(.WIDTH(16), .GROUP(4), .STAGES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout)
`ifdef CLA_PIPE_OVF_EN
    , .ovf(s_ovf)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // {cout, sum}: addition is a plain wide add; subtraction is a wide difference
  // whose borrow is the inverse of cout.
  function automatic logic [32:0] model32(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
    logic [32:0] r;
    if (s) begin
      r = {1'b0, x} - {1'b0, y};
      return {~r[32], r[31:0]};
    end
    r = {1'b0, x} + {1'b0, y} + {32'd0, c};
    return r;
  endfunction

  function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
    logic [16:0] r;
    if (s) begin
      r = {1'b0, x} - {1'b0, y};
      return {~r[16], r[15:0]};
    end
    r = {1'b0, x} + {1'b0, y} + {16'd0, c};
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive32(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic s);
    in_valid = v; a = x; b = y; cin = c; sub = s;
  endtask

  task automatic drive16(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic s);
    s_in_valid = v; s_a = x; s_b = y; s_cin = c; s_sub = s;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (sum !== 32'd0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset16 got out_valid=%b in_ready=%b exp 0/1", s_out_valid, s_in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_carry_chain();
    int lat;
    logic seen;
    drive32(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL carry_accept in_ready=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; seen = 1'b0;
    while (lat <= 10) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1; lat++;
    end
    checks++; if (!seen) begin errors++; $display("FAIL carry_timeout no out_valid within 10 cycles"); end
    checks++; if (lat != 2) begin errors++; $display("FAIL carry_latency got=%0d exp=2", lat); end
    checks++; if (sum !== 32'h0000_0000) begin errors++; $display("FAIL carry_sum got=%h exp=00000000", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL carry_cout got=%b exp=1", cout); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL carry_once out_valid=%b exp=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    logic [31:0] va[8], vb[8];
    logic        vc[8], vs[8];
    logic [32:0] fixed[3];
    logic [32:0] e;
    logic        seen;
    int          lat;
    va[0] = 32'd5; vb[0] = 32'd7; vc[0] = 1'b0; vs[0] = 1'b1; fixed[0] = {1'b0, 32'hFFFF_FFFE};
    va[1] = 32'd7; vb[1] = 32'd5; vc[1] = 1'b0; vs[1] = 1'b1; fixed[1] = {1'b1, 32'h0000_0002};
    va[2] = 32'd7; vb[2] = 32'd5; vc[2] = 1'b1; vs[2] = 1'b1; fixed[2] = {1'b1, 32'h0000_0002};
    for (int i = 3; i < 8; i++) begin
      va[i] = $urandom; vb[i] = $urandom;
      vc[i] = 1'($urandom_range(0, 1)); vs[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive32(1'b1, va[i], vb[i], vc[i], vs[i]);
      e = model32(va[i], vb[i], vc[i], vs[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1; seen = 1'b0;
      while (lat <= 10) begin
        @(negedge clk);
        if (out_valid) begin seen = 1'b1; break; end
        @(posedge clk); #1; lat++;
      end
      checks++;
      if (!seen || {cout, sum} !== e) begin
        errors++;
        $display("FAIL sub_vec%0d got valid=%b cout=%b sum=%h exp cout=%b sum=%h", i, seen, cout, sum, e[32], e[31:0]);
      end
      if (i < 3) begin
        checks++;
        if ({cout, sum} !== fixed[i]) begin
          errors++;
          $display("FAIL sub_table%0d got cout=%b sum=%h exp cout=%b sum=%h", i, cout, sum, fixed[i][32], fixed[i][31:0]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc, first_cyc, last_cyc;
    logic [31:0] ra, rb;
    logic        rc, acc;
    logic [32:0] e;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
    out_ready = 1'b1;
    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
    while (got < 100 && cyc < 300) begin
      if (sent < 100) drive32(1'b1, ra, rb, rc, 1'b0);
      else in_valid = 1'b0;
      @(negedge clk);
      acc = in_valid & in_ready;
      if (out_valid & out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra unexpected result sum=%h", sum);
        end else begin
          e = exp_q.pop_front();
          if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL stream_beat%0d got cout=%b sum=%h exp cout=%b sum=%h", got, cout, sum, e[32], e[31:0]);
          end
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(model32(ra, rb, rc, 1'b0));
        sent++;
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      end
      #1; cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 100) begin errors++; $display("FAIL stream_count got=%0d exp=100", got); end
    checks++; if (first_cyc != 2) begin errors++; $display("FAIL stream_first_cycle got=%0d exp=2", first_cyc); end
    checks++; if (last_cyc - first_cyc != 99) begin errors++; $display("FAIL stream_rate span got=%0d exp=99", last_cyc - first_cyc); end
  endtask

  task automatic test_backpressure();
    int accepts, got, cyc, extra;
    logic [31:0] ra, rb;
    logic        rc, rs, acc, tog;
    logic [32:0] e;
    exp_q.delete();
    accepts = 0;
    out_ready = 1'b0;
    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    for (int i = 0; i < 5; i++) begin
      drive32(1'b1, ra, rb, rc, rs);
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(model32(ra, rb, rc, rs));
        accepts++;
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      end
      #1;
    end
    checks++; if (accepts != 2) begin errors++; $display("FAIL bp_accepts got=%0d exp=2", accepts); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0 || {cout, sum} !== exp_q[0]) begin
      errors++; $display("FAIL bp_hold got cout=%b sum=%h", cout, sum);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb got=%b exp=1", in_ready); end
    got = 0; cyc = 0; tog = 1'b1;
    while (got < 2 && cyc < 20) begin
      out_ready = tog;
      @(negedge clk);
      if (out_valid & out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra unexpected result sum=%h", sum);
        end else begin
          e = exp_q.pop_front();
          if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL bp_beat%0d got cout=%b sum=%h exp cout=%b sum=%h", got, cout, sum, e[32], e[31:0]);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      tog = ~tog; cyc++;
    end
    checks++; if (got != 2) begin errors++; $display("FAIL bp_drain_count got=%0d exp=2", got); end
    out_ready = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL bp_duplicate got=%0d extra results exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int extra;
    out_ready = 1'b1;
    drive32(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive32(1'b1, $urandom, $urandom, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre out_valid=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_drop out_valid=%b exp=0", out_valid); end
    checks++; if (sum !== 32'd0 || cout !== 1'b0) begin errors++; $display("FAIL rst_mid_data got cout=%b sum=%h exp 0/0", cout, sum); end
    #1 rst_n = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL rst_mid_ghost got=%0d results exp=0", extra); end
  endtask

  task automatic test_small_config();
    int lat, sent, got, cyc;
    logic seen, acc;
    logic [15:0] ra, rb;
    logic rc, rs;
    logic [16:0] e;
    s_out_ready = 1'b1;
    drive16(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 1; seen = 1'b0;
    while (lat <= 12) begin
      @(negedge clk);
      if (s_out_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1; lat++;
    end
    checks++; if (!seen || lat != 4) begin errors++; $display("FAIL w16_latency got=%0d seen=%b exp=4", lat, seen); end
    checks++; if (s_sum !== 16'h0000 || s_cout !== 1'b1) begin
      errors++; $display("FAIL w16_carry got cout=%b sum=%h exp cout=1 sum=0000", s_cout, s_sum);
    end
    @(posedge clk); #1;
    exp16_q.delete();
    sent = 0; got = 0; cyc = 0;
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    while (got < 30 && cyc < 200) begin
      if (sent < 30) drive16(1'b1, ra, rb, rc, rs);
      else s_in_valid = 1'b0;
      s_out_ready = 1'($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = s_in_valid & s_in_ready;
      if (s_out_valid & s_out_ready) begin
        checks++;
        if (exp16_q.size() == 0) begin
          errors++; $display("FAIL w16_extra unexpected result sum=%h", s_sum);
        end else begin
          e = exp16_q.pop_front();
          if ({s_cout, s_sum} !== e) begin
            errors++;
            $display("FAIL w16_beat%0d got cout=%b sum=%h exp cout=%b sum=%h", got, s_cout, s_sum, e[16], e[15:0]);
          end
        end
        got++;
      end
      @(posedge clk);
      if (acc) begin
        exp16_q.push_back(model16(ra, rb, rc, rs));
        sent++;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      end
      #1; cyc++;
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    checks++; if (got != 30) begin errors++; $display("FAIL w16_count got=%0d exp=30", got); end
  endtask

`ifdef CLA_PIPE_OVF_EN
  task automatic test_ovf();
    logic [31:0] va[4], vb[4];
    logic        vs[4];
    logic        eo, seen;
    logic [32:0] r;
    int          lat;
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h0000_0001; vs[0] = 1'b0;
    va[1] = 32'h0000_0001; vb[1] = 32'h0000_0001; vs[1] = 1'b0;
    va[2] = 32'h8000_0000; vb[2] = 32'h0000_0001; vs[2] = 1'b1;
    va[3] = $urandom;      vb[3] = $urandom;      vs[3] = 1'($urandom_range(0, 1));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r = model32(va[i], vb[i], 1'b0, vs[i]);
      // Signed overflow: operands of matching effective sign give a result of the other sign.
      if (vs[i]) eo = (va[i][31] != vb[i][31]) && (r[31] != va[i][31]);
      else       eo = (va[i][31] == vb[i][31]) && (r[31] != va[i][31]);
      drive32(1'b1, va[i], vb[i], 1'b0, vs[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1; seen = 1'b0;
      while (lat <= 10) begin
        @(negedge clk);
        if (out_valid) begin seen = 1'b1; break; end
        @(posedge clk); #1; lat++;
      end
      checks++;
      if (!seen || ovf !== eo) begin
        errors++; $display("FAIL ovf_vec%0d got valid=%b ovf=%b exp ovf=%b", i, seen, ovf, eo);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    s_out_ready = 1'b0;
    test_reset();
    test_carry_chain();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_small_config();
`ifdef CLA_PIPE_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
